// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC mode encodings and the default reset vector.
package cpu_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'b000,
    PC_BRANCH = 3'b001,
    PC_JUMP   = 3'b010,
    PC_JR     = 3'b011,
    PC_CALL   = 3'b100,
    PC_RET    = 3'b101,
    PC_CALLR  = 3'b110,
    PC_RSVD   = 3'b111
  } pc_src_e;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the CPU control path (master) and the PC unit (slave).
interface pc_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned JIDX_W = 26
);

  logic              PCWre;
  pc_src_e           PCSrc;
  logic [ADDR_W-1:0] branchOff;
  logic [JIDX_W-1:0] jumpIdx;
  logic [ADDR_W-1:0] regTarget;
  logic [ADDR_W-1:0] pcOut;
  logic [ADDR_W-1:0] pcPlus4;
  logic              rasEmpty;
  logic              rasFull;
  logic              rasUnderflow;
  logic              misalignErr;

  modport master (
    output PCWre, PCSrc, branchOff, jumpIdx, regTarget,
    input  pcOut, pcPlus4, rasEmpty, rasFull, rasUnderflow, misalignErr
  );

  modport slave (
    input  PCWre, PCSrc, branchOff, jumpIdx, regTarget,
    output pcOut, pcPlus4, rasEmpty, rasFull, rasUnderflow, misalignErr
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pushData,
  output logic [ADDR_W-1:0] topData,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; validity is tracked by the count alone.
  always_ff @(posedge CLK) begin
    if (push) mem_q[ptr_q] <= pushData;
  end

  assign topData = mem_q[ptr_q - PtrW'(1)];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntMax);

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with next-PC selection, stall, and internal return-address stack.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned JIDX_W    = 26
) (
  input  logic     CLK,
  input  logic     Reset,
  pc_unit_if.slave bus
);

  localparam int unsigned JfW = JIDX_W + 2;
  localparam logic [ADDR_W-1:0] Four      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);
  // Upper bits kept from seq on a region jump; all-zero when the field covers the whole PC.
  localparam logic [ADDR_W-1:0] RegionMask = ~((ADDR_W'(1) << JfW) - ADDR_W'(1));

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              unf_q, unf_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] seq, reg_tgt, jump_tgt, ras_top;
  logic              ras_push, ras_pop, ras_empty, ras_full;
  logic              reg_misaligned;

  assign seq            = pc_q + Four;
  assign reg_tgt        = bus.regTarget & AlignMask;
  assign reg_misaligned = |bus.regTarget[1:0];
  assign jump_tgt       = (seq & RegionMask) | (ADDR_W'({bus.jumpIdx, 2'b00}) & ~RegionMask);

  always_comb begin
    pc_d     = pc_q;
    unf_d    = 1'b0;
    mis_d    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (bus.PCWre) begin
      case (bus.PCSrc)
        PC_BRANCH: pc_d = seq + (bus.branchOff << 2);
        PC_JUMP:   pc_d = jump_tgt;
        PC_JR: begin
          pc_d  = reg_tgt;
          mis_d = reg_misaligned;
        end
        PC_CALL: begin
          pc_d     = jump_tgt;
          ras_push = 1'b1;
        end
        PC_RET: begin
          if (!ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d  = reg_tgt;
            unf_d = 1'b1;
            mis_d = reg_misaligned;
          end
        end
        PC_CALLR: begin
          pc_d     = reg_tgt;
          ras_push = 1'b1;
          mis_d    = reg_misaligned;
        end
        default:   pc_d = seq;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= ADDR_W'(RESET_VEC);
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      unf_q <= unf_d;
      mis_q <= mis_d;
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK      (CLK),
    .Reset    (Reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .pushData (seq),
    .topData  (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign bus.pcOut        = pc_q;
  assign bus.pcPlus4      = seq;
  assign bus.rasEmpty     = ras_empty;
  assign bus.rasFull      = ras_full;
  assign bus.rasUnderflow = unf_q;
  assign bus.misalignErr  = mis_q;

endmodule
